// File: rtl/lcd_pkg.sv
// lcd_pkg: shared types and constants for the LCD page writer.
// Also holds the built-in page text used by lcd_page_rom.
package lcd_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CLEAR = 3'd1,
      ST_ADDR  = 3'd2,
      ST_CHAR  = 3'd3,
      ST_DONE  = 3'd4
   } lcd_pw_state_t;

   localparam logic [7:0]  LCD_CMD_CLEAR         = 8'h01;
   localparam logic [7:0]  LCD_CHAR_SPACE        = 8'h20;
   localparam logic [7:0]  LCD_CHAR_TERM         = 8'h00;
   // DDRAM address commands, line 0 in the most significant byte.
   localparam logic [31:0] LCD_LINE_ADDR_DEFAULT = {8'h80, 8'hC0, 8'h94, 8'hD4};

   // Pick the DDRAM address command for a line out of the packed table.
   function automatic logic [7:0] lcd_line_addr(input logic [31:0] tbl, input logic [1:0] idx);
      logic [7:0] a;
      case (idx)
         2'd0:    a = tbl[31:24];
         2'd1:    a = tbl[23:16];
         2'd2:    a = tbl[15:8];
         default: a = tbl[7:0];
      endcase
      return a;
   endfunction

   // Built-in page text: line 0 is upper case, line 1 lower case, both offset
   // by the page number. Page 2 line 0 ends early with a terminator at column 5.
   function automatic logic [7:0] lcd_rom_default(input int unsigned page,
                                                  input int unsigned line,
                                                  input int unsigned col);
      logic [7:0] base;
      logic [7:0] v;
      case (line[1:0])
         2'd0:    base = 8'h41;
         2'd1:    base = 8'h61;
         2'd2:    base = 8'h30;
         default: base = 8'h23;
      endcase
      if ((page == 32'd2) && (line == 32'd0) && (col == 32'd5)) begin
         v = LCD_CHAR_TERM;
      end else begin
         v = base + page[7:0] + col[7:0];
         if (v == LCD_CHAR_TERM) begin
            v = LCD_CHAR_SPACE;
         end else begin
            v = v;
         end
      end
      return v;
   endfunction

endpackage

// File: rtl/lcd_page_rom.sv
// lcd_page_rom: page text store addressed by {page, line, col}.
// Combinational 8-bit read; contents come from lcd_pkg::lcd_rom_default.
module lcd_page_rom
   import lcd_pkg::*;
#(
   parameter int N_PAGES = 4,
   parameter int LINES   = 2,
   parameter int COLS    = 16,
   parameter int PW      = 2,
   parameter int LW      = 1,
   parameter int CW      = 4
) (
   input  logic [PW+LW+CW-1:0] i_addr,
   output logic [7:0]          o_data
);

   logic [PW-1:0] w_page;
   logic [LW-1:0] w_line;
   logic [CW-1:0] w_col;

   assign {w_page, w_line, w_col} = i_addr;

   // Character lookup; addresses outside the stored text read as blanks.
   always_comb begin
      if ((32'(w_page) < 32'(N_PAGES)) && (32'(w_line) < 32'(LINES)) && (32'(w_col) < 32'(COLS))) begin
         o_data = lcd_rom_default(32'(w_page), 32'(w_line), 32'(w_col));
      end else begin
         o_data = LCD_CHAR_SPACE;
      end
   end

endmodule

// File: rtl/lcd_page_writer.sv
// lcd_page_writer: streams one stored text page to an HD44780-style LCD driver:
// clear command, then per line a DDRAM address command and the line's text.
// up/down select the page (with wrap) and trigger a redraw; valid/ready paced.
// Build macro LCD_PAGE_PAD_EN: pad a terminated line with spaces to full width.
module lcd_page_writer
   import lcd_pkg::*;
#(
   parameter int          N_PAGES   = 4,
   parameter int          LINES     = 2,
   parameter int          COLS      = 16,
   parameter logic [31:0] LINE_ADDR = LCD_LINE_ADDR_DEFAULT
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wrmenu,
   input  logic                       up,
   input  logic                       down,
   input  logic                       ready,
   output logic [7:0]                 dbi,
   output logic                       wr,
   output logic                       dr,
   output logic                       busy,
   output logic [$clog2(N_PAGES)-1:0] pag
);

   localparam int PW = $clog2(N_PAGES);
   localparam int LW = (LINES > 1) ? $clog2(LINES) : 1;
   localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

   lcd_pw_state_t r_state, w_state_nxt, w_eol_state;
   logic [LW-1:0] r_line, w_line_nxt, w_line_inc, w_eol_line;
   logic [CW-1:0] r_col, w_col_nxt, w_col_inc, w_rom_col;
   logic [PW-1:0] r_pag, r_rom_page, w_rom_page_nxt;
   logic [7:0]    r_dbi, w_dbi_nxt, w_eol_dbi, w_rom_data;
   logic          r_wr, r_dr, r_busy, w_wr_nxt, w_dr_nxt, w_busy_nxt, w_eol_dr;
   logic          r_pending, w_pend_clr, r_up_d, r_down_d;
   logic          w_step_up, w_step_dn, w_accept, w_last_col, w_last_line, w_rom_term;
`ifdef LCD_PAGE_PAD_EN
   logic          r_pad, w_pad_nxt;
`endif

   assign w_accept    = (r_wr | r_dr) & ready;
   assign w_step_up   = (up & ~r_up_d) & ~(down & ~r_down_d);
   assign w_step_dn   = (down & ~r_down_d) & ~(up & ~r_up_d);
   assign w_last_col  = (r_col == CW'(COLS - 1));
   assign w_last_line = (r_line == LW'(LINES - 1));
   assign w_col_inc   = r_col + CW'(1);
   assign w_line_inc  = r_line + LW'(1);
   assign w_rom_term  = (w_rom_data == LCD_CHAR_TERM);

   // The ROM always looks one character ahead: column 0 from ADDR, col+1 from CHAR.
   always_comb begin
      if ((r_state == ST_CHAR) && !w_last_col) begin
         w_rom_col = w_col_inc;
      end else begin
         w_rom_col = '0;
      end
   end

   lcd_page_rom #(
      .N_PAGES (N_PAGES),
      .LINES   (LINES),
      .COLS    (COLS),
      .PW      (PW),
      .LW      (LW),
      .CW      (CW)
   ) u_rom (
      .i_addr  ({r_rom_page, r_line, w_rom_col}),
      .o_data  (w_rom_data)
   );

   // End of a line: either address the next line or finish the page.
   always_comb begin
      if (w_last_line) begin
         w_eol_state = ST_DONE;
         w_eol_line  = r_line;
         w_eol_dbi   = r_dbi;
         w_eol_dr    = 1'b0;
      end else begin
         w_eol_state = ST_ADDR;
         w_eol_line  = w_line_inc;
         w_eol_dbi   = lcd_line_addr(LINE_ADDR, 2'(w_line_inc));
         w_eol_dr    = 1'b1;
      end
   end

   // Draw sequencer: next state and next registered strobe/byte values.
   always_comb begin
      w_state_nxt    = r_state;
      w_line_nxt     = r_line;
      w_col_nxt      = r_col;
      w_dbi_nxt      = r_dbi;
      w_wr_nxt       = r_wr;
      w_dr_nxt       = r_dr;
      w_busy_nxt     = r_busy;
      w_rom_page_nxt = r_rom_page;
      w_pend_clr     = 1'b0;
`ifdef LCD_PAGE_PAD_EN
      w_pad_nxt      = r_pad;
`endif
      case (r_state)
         ST_IDLE: begin
            if (wrmenu || r_pending) begin
               w_state_nxt    = ST_CLEAR;
               w_dbi_nxt      = LCD_CMD_CLEAR;
               w_dr_nxt       = 1'b1;
               w_wr_nxt       = 1'b0;
               w_busy_nxt     = 1'b1;
               w_rom_page_nxt = r_pag;
               w_pend_clr     = 1'b1;
            end else begin
               w_wr_nxt   = 1'b0;
               w_dr_nxt   = 1'b0;
               w_busy_nxt = 1'b0;
            end
         end
         ST_CLEAR: begin
            if (w_accept) begin
               w_state_nxt = ST_ADDR;
               w_line_nxt  = '0;
               w_dbi_nxt   = lcd_line_addr(LINE_ADDR, 2'd0);
            end else begin
               w_state_nxt = ST_CLEAR;
            end
         end
         ST_ADDR: begin
            if (w_accept) begin
`ifdef LCD_PAGE_PAD_EN
               w_state_nxt = ST_CHAR;
               w_col_nxt   = '0;
               w_dr_nxt    = 1'b0;
               w_wr_nxt    = 1'b1;
               if (w_rom_term) begin
                  w_pad_nxt = 1'b1;
                  w_dbi_nxt = LCD_CHAR_SPACE;
               end else begin
                  w_pad_nxt = 1'b0;
                  w_dbi_nxt = w_rom_data;
               end
`else
               if (w_rom_term) begin
                  w_state_nxt = w_eol_state;
                  w_line_nxt  = w_eol_line;
                  w_dbi_nxt   = w_eol_dbi;
                  w_dr_nxt    = w_eol_dr;
                  w_wr_nxt    = 1'b0;
               end else begin
                  w_state_nxt = ST_CHAR;
                  w_col_nxt   = '0;
                  w_dr_nxt    = 1'b0;
                  w_wr_nxt    = 1'b1;
                  w_dbi_nxt   = w_rom_data;
               end
`endif
            end else begin
               w_state_nxt = ST_ADDR;
            end
         end
         ST_CHAR: begin
            if (w_accept) begin
               if (w_last_col) begin
                  w_state_nxt = w_eol_state;
                  w_line_nxt  = w_eol_line;
                  w_dbi_nxt   = w_eol_dbi;
                  w_dr_nxt    = w_eol_dr;
                  w_wr_nxt    = 1'b0;
`ifdef LCD_PAGE_PAD_EN
               end else if (r_pad || w_rom_term) begin
                  w_col_nxt   = w_col_inc;
                  w_pad_nxt   = 1'b1;
                  w_dbi_nxt   = LCD_CHAR_SPACE;
`else
               end else if (w_rom_term) begin
                  w_state_nxt = w_eol_state;
                  w_line_nxt  = w_eol_line;
                  w_dbi_nxt   = w_eol_dbi;
                  w_dr_nxt    = w_eol_dr;
                  w_wr_nxt    = 1'b0;
`endif
               end else begin
                  w_col_nxt   = w_col_inc;
                  w_dbi_nxt   = w_rom_data;
               end
            end else begin
               w_state_nxt = ST_CHAR;
            end
         end
         ST_DONE: begin
            w_state_nxt = ST_IDLE;
            w_wr_nxt    = 1'b0;
            w_dr_nxt    = 1'b0;
            w_busy_nxt  = 1'b0;
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_wr_nxt    = 1'b0;
            w_dr_nxt    = 1'b0;
            w_busy_nxt  = 1'b0;
         end
      endcase
   end

   // Sequencer state and registered LCD outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_line     <= '0;
         r_col      <= '0;
         r_dbi      <= 8'h00;
         r_wr       <= 1'b0;
         r_dr       <= 1'b0;
         r_busy     <= 1'b0;
         r_rom_page <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_line     <= w_line_nxt;
         r_col      <= w_col_nxt;
         r_dbi      <= w_dbi_nxt;
         r_wr       <= w_wr_nxt;
         r_dr       <= w_dr_nxt;
         r_busy     <= w_busy_nxt;
         r_rom_page <= w_rom_page_nxt;
      end
   end

`ifdef LCD_PAGE_PAD_EN
   // Remembers that the current line hit its terminator and is now padding.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pad <= 1'b0;
      end else begin
         r_pad <= w_pad_nxt;
      end
   end
`endif

   // Button edge detection, page index with wrap, and the one-deep redraw request.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_up_d    <= 1'b0;
         r_down_d  <= 1'b0;
         r_pag     <= '0;
         r_pending <= 1'b0;
      end else begin
         r_up_d   <= up;
         r_down_d <= down;
         if (w_step_up) begin
            r_pag <= (r_pag == PW'(N_PAGES - 1)) ? '0 : r_pag + PW'(1);
         end else if (w_step_dn) begin
            r_pag <= (r_pag == '0) ? PW'(N_PAGES - 1) : r_pag - PW'(1);
         end else begin
            r_pag <= r_pag;
         end
         if (w_step_up || w_step_dn) begin
            r_pending <= 1'b1;
         end else if (w_pend_clr) begin
            r_pending <= 1'b0;
         end else begin
            r_pending <= r_pending;
         end
      end
   end

   assign dbi  = r_dbi;
   assign wr   = r_wr;
   assign dr   = r_dr;
   assign busy = r_busy;
   assign pag  = r_pag;

endmodule

// File: tb/tb_lcd_page_writer.sv
// tb_lcd_page_writer: table-driven check of page draws, page changes,
// back-pressure and asynchronous reset for lcd_page_writer.
module tb_lcd_page_writer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       wrmenu = 1'b0;
   logic       up = 1'b0;
   logic       down = 1'b0;
   logic       ready = 1'b1;
   logic [7:0] dbi;
   logic       wr;
   logic       dr;
   logic       busy;
   logic [1:0] pag;

   always #5 clk = ~clk;

   lcd_page_writer #(
      .N_PAGES (4),
      .LINES   (2),
      .COLS    (16)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .wrmenu  (wrmenu),
      .up      (up),
      .down    (down),
      .ready   (ready),
      .dbi     (dbi),
      .wr      (wr),
      .dr      (dr),
      .busy    (busy),
      .pag     (pag)
   );

`ifdef LCD_PAGE_PAD_EN
   localparam int PG2_COUNT = 35;
`else
   localparam int PG2_COUNT = 24;
`endif

   // trig: 0 = wrmenu, 1 = up, 2 = down, 3 = automatic redraw from pending
   typedef struct {
      int trig;
      int rmode;
      int exp_page;
      int exp_count;
      int inj_up;
   } vec_t;

   vec_t       vecs[8];
   int         total = 0;
   int         bad = 0;
   int         cyc = 0;
   int         rmode = 1;
   int         busy_cnt = 0;
   bit         hold_v = 1'b0;
   logic [9:0] hold_val;
   logic [8:0] got_q[$];
   logic [8:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // One clock: drive ready after the edge, observe the bus at the falling edge.
   task automatic step();
      @(posedge clk);
      #1;
      case (rmode)
         0:       ready = 1'b0;
         1:       ready = 1'b1;
         default: ready = ((cyc % rmode) == 0);
      endcase
      cyc++;
      @(negedge clk);
      if (wr || dr) check("one_strobe", {31'd0, wr & dr}, 32'd0);
      if (hold_v) check("held_until_accept", {22'd0, wr, dr, dbi}, {22'd0, hold_val});
      hold_v   = (wr || dr) && !ready;
      hold_val = {wr, dr, dbi};
      if ((wr || dr) && ready) got_q.push_back({dr, dbi});
      if (busy) busy_cnt++;
   endtask

   function automatic logic [7:0] exp_byte(input int p, input int l, input int c);
      logic [7:0] b;
      if (p == 2 && l == 0 && c == 5) return 8'h00;
      b = (l == 0) ? 8'h41 : 8'h61;
      return b + 8'(p) + 8'(c);
   endfunction

   task automatic build_exp(input int p);
      exp_q.delete();
      exp_q.push_back({1'b1, 8'h01});
      for (int l = 0; l < 2; l++) begin
         exp_q.push_back({1'b1, (l == 0) ? 8'h80 : 8'hC0});
         for (int c = 0; c < 16; c++) begin
            if (exp_byte(p, l, c) == 8'h00) begin
`ifdef LCD_PAGE_PAD_EN
               for (int k = c; k < 16; k++) exp_q.push_back({1'b0, 8'h20});
`endif
               break;
            end
            exp_q.push_back({1'b0, exp_byte(p, l, c)});
         end
      end
   endtask

   task automatic compare_draw(input int p, input int exp_count);
      build_exp(p);
      check($sformatf("count_page%0d", p), got_q.size(), exp_count);
      for (int k = 0; k < exp_q.size(); k++) begin
         if (k < got_q.size()) check($sformatf("xfer%0d_page%0d", k, p), {23'd0, got_q[k]}, {23'd0, exp_q[k]});
      end
   endtask

   task automatic run_to_idle(input int inj_up, input int exp_page);
      int n;
      n = 0;
      while (busy && n < 400) begin
         if (n == inj_up) up = 1'b1;
         step();
         if (up) begin
            up = 1'b0;
            check("pag_during_draw", {30'd0, pag}, (exp_page + 1) % 4);
         end
         n++;
      end
      check("draw_end", {31'd0, busy}, 32'd0);
   endtask

   initial begin
      bit ok;
      bit seen;
      int n;

      vecs[0] = '{0, 1, 0, 35, -1};
      vecs[1] = '{0, 3, 0, 35, -1};
      vecs[2] = '{2, 1, 3, 35, -1};
      vecs[3] = '{1, 1, 0, 35, -1};
      vecs[4] = '{1, 1, 1, 35, -1};
      vecs[5] = '{1, 3, 2, PG2_COUNT, -1};
      vecs[6] = '{2, 1, 1, 35, 10};
      vecs[7] = '{3, 1, 2, PG2_COUNT, -1};

      step();
      step();
      rst = 1'b0;
      check("rst_dbi", {24'd0, dbi}, 32'd0);
      check("rst_strobes", {29'd0, wr, dr, busy}, 32'd0);
      check("rst_pag", {30'd0, pag}, 32'd0);
      step();
      step();
      check("idle_quiet", {29'd0, wr, dr, busy}, 32'd0);

      for (int i = 0; i < 8; i++) begin
         got_q.delete();
         busy_cnt = 0;
         hold_v   = 1'b0;
         rmode    = vecs[i].rmode;
         case (vecs[i].trig)
            0: begin
               wrmenu = 1'b1;
               step();
               wrmenu = 1'b0;
               check("wrmenu_clear", {22'd0, busy, dr, dbi}, {22'd0, 2'b11, 8'h01});
            end
            1, 2: begin
               if (vecs[i].trig == 1) up = 1'b1;
               else down = 1'b1;
               step();
               up   = 1'b0;
               down = 1'b0;
               check("pag_after_edge", {30'd0, pag}, vecs[i].exp_page);
               check("no_strobe_yet", {29'd0, wr, dr, busy}, 32'd0);
               step();
               check("change_clear", {22'd0, busy, dr, dbi}, {22'd0, 2'b11, 8'h01});
            end
            default: begin
               ok = 1'b0;
               for (int k = 0; k < 5; k++) begin
                  step();
                  if (busy) begin
                     ok = 1'b1;
                     break;
                  end
               end
               check("auto_redraw", {31'd0, ok}, 32'd1);
            end
         endcase
         run_to_idle(vecs[i].inj_up, vecs[i].exp_page);
         compare_draw(vecs[i].exp_page, vecs[i].exp_count);
         if (vecs[i].rmode == 1) check("busy_cycles", busy_cnt, vecs[i].exp_count + 1);
      end

      // A change during the page 1 draw must redraw page 2 exactly once.
      seen = 1'b0;
      for (int k = 0; k < 12; k++) begin
         step();
         if (busy) seen = 1'b1;
      end
      check("no_double_draw", {31'd0, seen}, 32'd0);

      // Reset in the middle of a stalled character transfer.
      rmode  = 1;
      wrmenu = 1'b1;
      step();
      wrmenu = 1'b0;
      n = 0;
      while (!wr && n < 20) begin
         step();
         n++;
      end
      check("reach_char", {31'd0, wr}, 32'd1);
      rmode = 0;
      step();
      step();
      #2;
      rst    = 1'b1;
      hold_v = 1'b0;
      #1;
      check("async_rst_strobes", {29'd0, wr, dr, busy}, 32'd0);
      check("async_rst_pag", {30'd0, pag}, 32'd0);
      check("async_rst_dbi", {24'd0, dbi}, 32'd0);
      rmode = 1;
      step();
      rst    = 1'b0;
      hold_v = 1'b0;
      step();
      check("post_rst_idle", {31'd0, busy}, 32'd0);
      got_q.delete();
      busy_cnt = 0;
      wrmenu   = 1'b1;
      step();
      wrmenu = 1'b0;
      check("post_rst_clear", {22'd0, busy, dr, dbi}, {22'd0, 2'b11, 8'h01});
      run_to_idle(-1, 0);
      compare_draw(0, 35);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
